pixel_plot_sink: RTL and testbench
==================================

PIXEL_PLOT_SINK -- requirements
Module: pixel_plot_sink

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous reset, active-high.
REQ-004 iX  input  8  pixel column, valid 0..159.
REQ-005 iY  input  7  pixel row, valid 0..119.
REQ-006 iColour  input  9  pixel colour, 3 bits per channel.
REQ-007 iPlot  input  1  plot request; a plot is accepted on an edge where iPlot=1 and oReady=1.
REQ-008 oReady  output  1  block can accept a plot this cycle.
REQ-009 fb_grant  input  1  framebuffer write port available this cycle.
REQ-010 fb_we  output  1  framebuffer write strobe.
REQ-011 fb_addr  output  15  framebuffer address.
REQ-012 fb_data  output  9  framebuffer write colour.
REQ-013 oDropCount  output  8  count of dropped out-of-range plots.
REQ-014 iClear  input  1  start a full-screen clear.
REQ-015 iClearColour  input  9  fill colour for a clear.
REQ-016 oClearDone  output  1  one-cycle pulse when a clear completes.

Function
REQ-017 An accepted in-range plot SHALL push {addr = iY*160 + iX, iColour} into a 4-entry FIFO; the address is computed before the push and is 15 bits wide (maximum 19199).
REQ-018 An accepted plot with iX>=160 or iY>=120 SHALL NOT be pushed and SHALL increment oDropCount, which saturates at 255.
REQ-019 oReady SHALL equal (FIFO not full) AND (state = RUN); a pop in the same cycle SHALL NOT lift a full condition.
REQ-020 In RUN, fb_we SHALL equal (FIFO not empty) AND fb_grant, with fb_addr and fb_data taken from the FIFO head; the FIFO SHALL pop on every cycle where fb_we=1.
REQ-021 Latency: a plot pushed at edge N SHALL appear on fb_* no earlier than cycle N+1, and only when fb_grant is high; there is no empty-FIFO bypass.
REQ-022 Entries SHALL be written in acceptance order; no entry SHALL be lost or duplicated across fb_grant gaps.
REQ-023 When fb_we=0, fb_addr and fb_data SHALL hold their previous values.
REQ-024 The state machine SHALL have three states: RUN, DRAIN and CLEAR.
REQ-025 RUN to DRAIN SHALL occur on an edge where iClear=1; the same cycle's plot SHALL still be accepted if oReady was 1.
REQ-026 In DRAIN, the FIFO SHALL continue draining per REQ-020; the state SHALL move from DRAIN to CLEAR on the edge where the FIFO becomes empty.
REQ-027 In CLEAR, the block SHALL write iClearColour (latched on entry) to addresses 0..19199, one address per cycle with fb_grant=1, and SHALL hold the address when fb_grant=0.
REQ-028 After the write to address 19199, the state SHALL return to RUN and oClearDone SHALL pulse for exactly one cycle.
REQ-029 iClear SHALL be ignored in DRAIN and CLEAR.

Reset
REQ-030 Reset SHALL set: state RUN, FIFO empty, oReady=1, fb_we=0, fb_addr=0, fb_data=0, oDropCount=0, oClearDone=0 and the clear counter to 0.
REQ-031 Reset mid-clear or mid-drain SHALL abort immediately, discard FIFO contents and produce no oClearDone pulse.

Configuration
REQ-032 With PIXEL_PLOT_SINK_CLEAR_EN defined, the block SHALL implement DRAIN, CLEAR and the clear ports as specified above.
REQ-033 Without PIXEL_PLOT_SINK_CLEAR_EN, the ports SHALL remain, iClear and iClearColour SHALL be ignored, oClearDone SHALL be constant 0, and the state SHALL stay in RUN.

Structure
REQ-034 The shared package plot_pkg SHALL hold: SCREEN_W=160, SCREEN_H=120, ADDR_W=15, COLOUR_W=9, FIFO_DEPTH=4, and the state enum.
REQ-035 The FIFO SHALL be the sub-module plot_fifo, a synchronous circular buffer with full and empty flags.

Verification
REQ-036 Plot (3,2,0x1FF) with fb_grant=1: fb_we in the next cycle, fb_addr=323, fb_data=0x1FF.
REQ-037 fb_grant=0, five back-to-back plots: four accepted, oReady=0 on the fifth; with fb_grant=1 the four writes emerge in order, then oReady returns to 1.
REQ-038 Plots (160,0) and (0,120), and 300 plots at (200,5): nothing is written; oDropCount counts to 255 and holds there.
REQ-039 Three entries queued, then iClear with colour 0x049: the three queued writes complete first, then 19200 writes of 0x049 covering addresses 0..19199, then one oClearDone pulse and oReady=1.
REQ-040 Reset asserted at clear address 5000: all outputs reach their reset values asynchronously, no oClearDone pulse occurs, and a subsequent plot works normally.
REQ-041 Build without the macro, pulse iClear: no state change, oClearDone stays 0 and oReady stays 1.

Source files
------------

// File: rtl/plot_pkg.sv
// plot_pkg: shared constants, FSM state type and address helper for the
// pixel_plot_sink block.
//   SCREEN_W/SCREEN_H : visible raster size (160 x 120)
//   ADDR_W/COLOUR_W   : framebuffer address / colour widths
//   FIFO_DEPTH        : plot queue depth
//   state_e           : RUN / DRAIN / CLEAR
package plot_pkg;

  localparam logic [7:0] SCREEN_W   = 8'd160;
  localparam logic [6:0] SCREEN_H   = 7'd120;
  localparam int         ADDR_W     = 15;
  localparam int         COLOUR_W   = 9;
  localparam int         FIFO_DEPTH = 4;

  // Last framebuffer address (160*120 - 1).
  localparam logic [ADDR_W-1:0] CLEAR_LAST = 15'd19199;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // Linear framebuffer address y*160 + x; fits in 15 bits for in-range pixels.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] row;
    row = {8'd0, y} * {7'd0, SCREEN_W};
    return row + {7'd0, x};
  endfunction

endpackage

// File: rtl/pixel_plot_sink_if.sv
// pixel_plot_sink_if: plot request, framebuffer write and clear signals.
//   slave  : the pixel_plot_sink side (consumes plots, drives fb_*)
//   master : the environment side (issues plots, grants the framebuffer)
interface pixel_plot_sink_if;
  import plot_pkg::*;

  logic [7:0]          iX;
  logic [6:0]          iY;
  logic [COLOUR_W-1:0] iColour;
  logic                iPlot;
  logic                oReady;
  logic                fb_grant;
  logic                fb_we;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_data;
  logic [7:0]          oDropCount;
  logic                iClear;
  logic [COLOUR_W-1:0] iClearColour;
  logic                oClearDone;

  modport slave (
    input  iX, iY, iColour, iPlot, fb_grant, iClear, iClearColour,
    output oReady, fb_we, fb_addr, fb_data, oDropCount, oClearDone
  );

  modport master (
    output iX, iY, iColour, iPlot, fb_grant, iClear, iClearColour,
    input  oReady, fb_we, fb_addr, fb_data, oDropCount, oClearDone
  );
endinterface

// File: rtl/plot_fifo.sv
// plot_fifo: synchronous circular-buffer FIFO with full/empty flags.
//   clock, reset : clock and asynchronous active-high reset
//   push, din    : write request and data (ignored when full)
//   pop, dout    : read request (ignored when empty) and head data
//   full, empty  : occupancy flags; count : current occupancy
module plot_fifo
  import plot_pkg::*;
#(
  parameter int WIDTH = ADDR_W + COLOUR_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == CNT_W'(0));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer wrap and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= WIDTH'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end
endmodule

// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: queues pixel plots and writes them to a framebuffer port;
// optionally performs a full-screen clear after draining the queue.
//   clock, reset      : clock, asynchronous active-high reset
//   bus (slave)       : iX/iY/iColour/iPlot/oReady plot handshake,
//                       fb_grant/fb_we/fb_addr/fb_data framebuffer port,
//                       oDropCount, iClear/iClearColour/oClearDone
// Macro PIXEL_PLOT_SINK_CLEAR_EN enables the DRAIN/CLEAR behaviour; without
// it iClear is ignored and the block stays in RUN.
module pixel_plot_sink
  import plot_pkg::*;
(
  input logic              clock,
  input logic              reset,
  pixel_plot_sink_if.slave bus
);
  localparam int ENTRY_W = ADDR_W + COLOUR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [7:0]          drop_q, drop_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [COLOUR_W-1:0] clr_colour_q, clr_colour_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [COLOUR_W-1:0] last_data_q, last_data_d;
  logic                done_q, done_d;

  logic                in_range, ready, accept, push, pop, clr_we, clear_start;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  fifo_head;
  logic [ADDR_W-1:0]   fb_addr_s;
  logic [COLOUR_W-1:0] fb_data_s;

`ifdef PIXEL_PLOT_SINK_CLEAR_EN
  assign clear_start = bus.iClear;
`else
  assign clear_start = 1'b0;
`endif

  assign in_range = (bus.iX < SCREEN_W) && (bus.iY < SCREEN_H);
  // Full is judged on the registered count, so a same-cycle pop cannot free a slot.
  assign ready    = !fifo_full && (state_q == RUN);
  assign accept   = bus.iPlot && ready;
  assign push     = accept && in_range;
  // The FIFO is always empty in CLEAR, so this only fires in RUN/DRAIN.
  assign pop      = !fifo_empty && bus.fb_grant;
  assign clr_we   = (state_q == CLEAR) && bus.fb_grant;

  plot_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   ({pix_addr(bus.iX, bus.iY), bus.iColour}),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Framebuffer write mux; address/data hold their last values when idle.
  always_comb begin
    fb_addr_s = last_addr_q;
    fb_data_s = last_data_q;
    if (pop) begin
      fb_addr_s = fifo_head[ENTRY_W-1:COLOUR_W];
      fb_data_s = fifo_head[COLOUR_W-1:0];
    end else if (clr_we) begin
      fb_addr_s = clr_cnt_q;
      fb_data_s = clr_colour_q;
    end else begin
      fb_addr_s = last_addr_q;
      fb_data_s = last_data_q;
    end
  end

  assign bus.fb_we      = pop || clr_we;
  assign bus.fb_addr    = fb_addr_s;
  assign bus.fb_data    = fb_data_s;
  assign bus.oReady     = ready;
  assign bus.oDropCount = drop_q;
  assign bus.oClearDone = done_q;

  // Next-state logic: drop counter, held write values and RUN/DRAIN/CLEAR sequencing.
  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    clr_cnt_d    = clr_cnt_q;
    clr_colour_d = clr_colour_q;
    done_d       = 1'b0;
    last_addr_d  = fb_addr_s;
    last_data_d  = fb_data_s;

    if (accept && !in_range && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end

    case (state_q)
      RUN: begin
        if (clear_start) state_d = DRAIN;
        else             state_d = RUN;
      end
      DRAIN: begin
        // Leave on the edge at which the queue ends up empty.
        if (fifo_empty || (pop && (fifo_count == CNT_W'(1)))) begin
          state_d      = CLEAR;
          clr_cnt_d    = ADDR_W'(0);
          clr_colour_d = bus.iClearColour;
        end else begin
          state_d = DRAIN;
        end
      end
      CLEAR: begin
        if (clr_we && (clr_cnt_q == CLEAR_LAST)) begin
          state_d   = RUN;
          clr_cnt_d = ADDR_W'(0);
          done_d    = 1'b1;
        end else if (clr_we) begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end else begin
          clr_cnt_d = clr_cnt_q;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      drop_q       <= 8'd0;
      clr_cnt_q    <= ADDR_W'(0);
      clr_colour_q <= COLOUR_W'(0);
      last_addr_q  <= ADDR_W'(0);
      last_data_q  <= COLOUR_W'(0);
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_colour_q <= clr_colour_d;
      last_addr_q  <= last_addr_d;
      last_data_q  <= last_data_d;
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboard bench for pixel_plot_sink. Stimulus pushes expected {addr,data}
// writes into exp_q; a negedge monitor pops and compares every fb_we cycle.
// Define PIXEL_PLOT_SINK_CLEAR_EN to exercise the clear path.
module tb_pixel_plot_sink;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   done_pulses = 0;
  bit   sb_en = 1'b1;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;

  always #5 clock = ~clock;

  pixel_plot_sink_if bus();
  pixel_plot_sink dut (.clock(clock), .reset(reset), .bus(bus));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (!reset && sb_en && bus.fb_we) begin
      check("wr_grant", {31'd0, bus.fb_grant}, 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=%0d required none", bus.fb_addr, bus.fb_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {17'd0, bus.fb_addr}, {17'd0, mon_e[23:9]});
        check("wr_data", {23'd0, bus.fb_data}, {23'd0, mon_e[8:0]});
      end
    end
  end

  // Counts oClearDone cycles.
  always @(negedge clock) begin
    if (!reset && bus.oClearDone) done_pulses++;
  end

  // Issue one plot at posedge+1; returns at the next posedge+1.
  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [8:0] c,
                      input bit exp_acc, input string nm);
    int a;
    bus.iX = x; bus.iY = y; bus.iColour = c; bus.iPlot = 1'b1;
    check({nm, "_ready"}, {31'd0, bus.oReady}, {31'd0, exp_acc});
    if (exp_acc && x < 8'd160 && y < 7'd120) begin
      a = int'(y) * 160 + int'(x);
      exp_q.push_back({a[14:0], c});
    end
    @(posedge clock); #1;
    bus.iPlot = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int limit, input bit toggle);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      if (toggle) bus.fb_grant = n[0];
      else        bus.fb_grant = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    check({nm, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iX = 8'd0; bus.iY = 7'd0; bus.iColour = 9'd0; bus.iPlot = 1'b0;
    bus.fb_grant = 1'b0; bus.iClear = 1'b0; bus.iClearColour = 9'd0;
    reset = 1'b1;
    #2;
    check("rst_ready", {31'd0, bus.oReady}, 32'd1);
    check("rst_we",    {31'd0, bus.fb_we}, 32'd0);
    check("rst_addr",  {17'd0, bus.fb_addr}, 32'd0);
    check("rst_data",  {23'd0, bus.fb_data}, 32'd0);
    check("rst_drop",  {24'd0, bus.oDropCount}, 32'd0);
    check("rst_done",  {31'd0, bus.oClearDone}, 32'd0);
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;

    // Single plot, grant high: no bypass, write one cycle later.
    bus.fb_grant = 1'b1;
    check("lat_we_before", {31'd0, bus.fb_we}, 32'd0);
    plot(8'd3, 7'd2, 9'h1FF, 1'b1, "p323");
    check("p323_we",   {31'd0, bus.fb_we}, 32'd1);
    check("p323_addr", {17'd0, bus.fb_addr}, 32'd323);
    check("p323_data", {23'd0, bus.fb_data}, 32'h1FF);
    @(posedge clock); #1;
    check("hold_we",   {31'd0, bus.fb_we}, 32'd0);
    check("hold_addr", {17'd0, bus.fb_addr}, 32'd323);
    check("hold_data", {23'd0, bus.fb_data}, 32'h1FF);

    // Fill with grant low; fifth is refused.
    bus.fb_grant = 1'b0;
    plot(8'd0,   7'd0,   9'h001, 1'b1, "f0");
    plot(8'd159, 7'd0,   9'h002, 1'b1, "f1");
    plot(8'd0,   7'd119, 9'h003, 1'b1, "f2");
    plot(8'd159, 7'd119, 9'h004, 1'b1, "f3");
    plot(8'd5,   7'd5,   9'h005, 1'b0, "f4");
    check("full_we", {31'd0, bus.fb_we}, 32'd0);
    // A pop in the same cycle must not reopen a full queue.
    bus.fb_grant = 1'b1;
    plot(8'd7, 7'd7, 9'h007, 1'b0, "full_pop");
    wait_drain("fill", 20, 1'b0);
    check("fill_ready", {31'd0, bus.oReady}, 32'd1);

    // Grant gaps: order kept, nothing lost or duplicated.
    bus.fb_grant = 1'b0;
    plot(8'd1, 7'd1, 9'h011, 1'b1, "g0");
    plot(8'd2, 7'd1, 9'h022, 1'b1, "g1");
    plot(8'd3, 7'd1, 9'h033, 1'b1, "g2");
    wait_drain("gap", 30, 1'b1);

    // Out-of-range plots are dropped and counted, saturating at 255.
    bus.fb_grant = 1'b1;
    plot(8'd160, 7'd0,   9'h0F0, 1'b1, "oob_x");
    plot(8'd0,   7'd120, 9'h0F0, 1'b1, "oob_y");
    check("drop_2", {24'd0, bus.oDropCount}, 32'd2);
    for (int i = 0; i < 300; i++) begin
      plot(8'd200, 7'd5, 9'h0F0, 1'b1, "oob_loop");
      if (i == 99) check("drop_102", {24'd0, bus.oDropCount}, 32'd102);
    end
    check("drop_sat", {24'd0, bus.oDropCount}, 32'd255);
    check("drop_noq", exp_q.size(), 32'd0);

`ifdef PIXEL_PLOT_SINK_CLEAR_EN
    // Three queued plots, then a clear with colour 0x049.
    bus.fb_grant = 1'b0;
    plot(8'd10, 7'd0, 9'h101, 1'b1, "c0");
    plot(8'd11, 7'd0, 9'h102, 1'b1, "c1");
    plot(8'd12, 7'd0, 9'h103, 1'b1, "c2");
    bus.iClearColour = 9'h049;
    bus.iClear = 1'b1;
    for (int a = 0; a < 19200; a++) begin
      logic [14:0] a15;
      a15 = a[14:0];
      exp_q.push_back({a15, 9'h049});
    end
    @(posedge clock); #1;
    bus.iClear = 1'b0;
    check("drain_ready", {31'd0, bus.oReady}, 32'd0);
    wait_drain("clear", 25000, 1'b0);
    check("clr_done_hi",  {31'd0, bus.oClearDone}, 32'd1);
    check("clr_ready",    {31'd0, bus.oReady}, 32'd1);
    @(posedge clock); #1;
    check("clr_done_lo",  {31'd0, bus.oClearDone}, 32'd0);
    check("clr_pulses",   done_pulses, 32'd1);

    // Reset in the middle of a clear.
    sb_en = 1'b0;
    bus.iClear = 1'b1;
    @(posedge clock); #1;
    bus.iClear = 1'b0;
    begin
      int n = 0;
      while (!(bus.fb_we && bus.fb_addr == 15'd5000) && n < 8000) begin
        @(negedge clock);
        n++;
      end
    end
    check("rst_at5000", {17'd0, bus.fb_addr}, 32'd5000);
    #1 reset = 1'b1;
    #1;
    check("mrst_ready", {31'd0, bus.oReady}, 32'd1);
    check("mrst_we",    {31'd0, bus.fb_we}, 32'd0);
    check("mrst_addr",  {17'd0, bus.fb_addr}, 32'd0);
    check("mrst_data",  {23'd0, bus.fb_data}, 32'd0);
    check("mrst_drop",  {24'd0, bus.oDropCount}, 32'd0);
    check("mrst_done",  {31'd0, bus.oClearDone}, 32'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    sb_en = 1'b1;
    @(posedge clock); #1;
    plot(8'd10, 7'd1, 9'h0AA, 1'b1, "post_rst");
    wait_drain("post_rst", 20, 1'b0);
    check("mrst_pulses", done_pulses, 32'd1);
`else
    // Clear disabled: iClear has no effect.
    bus.fb_grant = 1'b1;
    bus.iClearColour = 9'h049;
    bus.iClear = 1'b1;
    @(posedge clock); #1;
    bus.iClear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("noclr_ready", {31'd0, bus.oReady}, 32'd1);
      check("noclr_done",  {31'd0, bus.oClearDone}, 32'd0);
      check("noclr_we",    {31'd0, bus.fb_we}, 32'd0);
      @(posedge clock); #1;
    end
    plot(8'd20, 7'd3, 9'h155, 1'b1, "noclr_plot");
    wait_drain("noclr", 20, 1'b0);
    check("noclr_pulses", done_pulses, 32'd0);
`endif

    check("final_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
